spislave_le: RTL and testbench
==============================

Name: spislave_le

Overview:
SPI slave for the J1a I/O space; the target-side counterpart of the on-chip SPI master.
- Lets the J1a sit on an external SPI bus as a responder, in the same SPI mode, bit order and byte order as that master.
- Exchanges 8-bit or 16-bit words with an external master.
- Presents received words and accepts transmit words through a CPU-side register interface.

Parameters:
SYNC_STAGES, 2, synchroniser depth on SCK, SS_N and MOSI (2 or 3)
IDLE_TX, 8'h00, byte shifted out on MISO when no transmit word is pending

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
we  in  1  CPU write strobe; loads tx and both into the holding register
both  in  1  word size written with we: 1 = 16-bit word, 0 = 8-bit word
tx  in  16  transmit data
rd  in  1  CPU read strobe; clears rx_ready
rx  out  16  last received word
rx_ready  out  1  sticky: a complete word is in rx
tx_empty  out  1  holding register free (safe to write)
selected  out  1  SS_N currently asserted (synchronised)
SCK  in  1  SPI clock from master
SS_N  in  1  slave select, active low
MOSI  in  1  serial data in
MISO  out  1  serial data out
MISO_OE  out  1  MISO output enable, equals selected

Behaviour:
- Reset: rx=0, rx_ready=0, tx_empty=1, selected=0, MISO=1, MISO_OE=0; shifters and counter cleared; synchronisers preset to idle (SCK=1, SS_N=1).
- SPI mode 3 (CPOL=1, CPHA=1):
  - SCK idles high.
  - Slave samples MOSI on the synchronised SCK rising edge.
  - Slave shifts MISO on the synchronised SCK falling edge.
  - MSB first within each byte.
- Timing limits: SCK period >= 8 clk; SS_N fall to first SCK fall >= 4 clk.
- Edge detection: each input passes through SYNC_STAGES flops plus one history flop; an edge is the XOR of the last two.
- FSM IDLE -> ACTIVE on SS_N fall:
  - Latch the word size from the holding register: both=1 gives 16 bits, else 8.
  - Load the TX shifter from the holding register and set tx_empty=1.
  - Drive the first MISO bit the same cycle.
  - If nothing is pending, load {IDLE_TX, IDLE_TX}.
- 16-bit send order: tx[7:0] then tx[15:8].
- 16-bit receive order: first byte received lands in rx[7:0], second in rx[15:8].
- 8-bit words: send tx[7:0]; rx = {8'h00, byte}.
- In ACTIVE, each SCK rise shifts MOSI into the RX shifter and increments the bit counter (0..15).
- On the rise completing the word (count = 7 or 15):
  - On the next clk: rx updated, rx_ready=1, counter=0.
  - Load the TX shifter from the holding register (or IDLE_TX) for back-to-back words, taking MSB out at the following SCK fall; word size is relatched.
- ACTIVE -> IDLE on SS_N rise, including mid-word:
  - Discard the partial word; rx and rx_ready unchanged.
  - Counter=0; MISO_OE=0; MISO=1.
  - A pending holding word not yet loaded stays pending.
- Word completes while rx_ready=1: rx overwritten, rx_ready stays 1.
- we and TX load in the same cycle: the load takes the old holding value, then the new write is stored and tx_empty=0.
- we while tx_empty=0: overwrites the holding register.
- rd and word completion in the same cycle: completion wins, rx_ready=1.

Optional Feature:
SPISLAVE_STATUS_EN
- Defined:
  - Adds output status[1:0], bit 0 = overrun, bit 1 = underrun, both sticky.
  - Overrun is set when a word completes while rx_ready=1.
  - Underrun is set when a TX load finds tx_empty=1.
  - Both bits clear on rd.
- Undefined: no status port and no flag logic; all other behaviour identical.

Decomposition:
- Shared package spi_pkg:
  - SPI mode constants (CPOL=1, CPHA=1).
  - Word-size enum WS8/WS16.
  - FSM state enum IDLE/ACTIVE.
  - Byte-swap helper function shared with the master.
- One natural sub-module: spi_sync_edge.
  - Synchroniser plus rise/fall detect, instanced for SCK and SS_N.
  - MOSI uses the plain synchroniser path of the same sub-module.

Test Plan:
- 8-bit: write tx=16'h00A5, both=0; master sends 8'h3C at clk/8 -> MISO bits 1010_0101; rx=16'h003C; rx_ready=1; tx_empty=1.
- 16-bit: tx=16'h1234, both=1; master sends bytes 8'hAB then 8'hCD -> MISO bytes 34 then 12; rx=16'hCDAB.
- Back-to-back 16-bit words under one SS_N, second tx=16'hBEEF written mid-first-word -> second word sends EF then BE; rx updated twice.
- SS_N released after 5 bits -> rx and rx_ready unchanged; next full frame received correctly from bit 0.
- No tx written, frame of 8 bits -> MISO shifts 8'h00; with SPISLAVE_STATUS_EN, status=2'b10; second unread word gives status=2'b11; rd clears it to 2'b00.
- Assert rst mid-word -> all outputs at reset values within the same cycle; a subsequent frame works normally.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions for the J1a SPI master and slave: mode constants,
// word-size and FSM state enums, and the byte-swap used for LSB-byte-first words.
package spi_pkg;

  localparam logic CPOL = 1'b1;
  localparam logic CPHA = 1'b1;

  typedef enum logic {
    WS8  = 1'b0,
    WS16 = 1'b1
  } wordSize_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spiState_e;

  function automatic logic [15:0] byteSwap(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with one history flop; rise/fall are the XOR of the
// synchronised level and its history, qualified by direction.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] syncChain_q;
  logic              history_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncChain_q <= {STAGES{RESET_VAL}};
      history_q   <= RESET_VAL;
    end else begin
      syncChain_q <= {syncChain_q[STAGES-2:0], d_i};
      history_q   <= syncChain_q[STAGES-1];
    end
  end

  assign q_o    = syncChain_q[STAGES-1];
  assign rise_o = q_o & ~history_q;
  assign fall_o = ~q_o & history_q;

endmodule

// File: rtl/spislave_le.sv
// SPI mode-3 slave for the J1a I/O space: 8/16-bit words, MSB-first bytes, low byte first.
// Define SPISLAVE_STATUS_EN to add the sticky overrun/underrun status port.
module spislave_le
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_TX     = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        both,
  input  logic [15:0] tx,
  input  logic        rd,
  output logic [15:0] rx,
  output logic        rx_ready,
  output logic        tx_empty,
  output logic        selected,
`ifdef SPISLAVE_STATUS_EN
  output logic [1:0]  status,
`endif
  input  logic        SCK,
  input  logic        SS_N,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_OE
);

  logic sckLevel, sckRise, sckFall;
  logic ssLevel, ssRise, ssFall;
  logic mosiSync, mosiRise, mosiFall;
  logic unusedSync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(CPOL)) uSckSync (
    .clk(clk), .rst(rst), .d_i(SCK), .q_o(sckLevel), .rise_o(sckRise), .fall_o(sckFall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uSsSync (
    .clk(clk), .rst(rst), .d_i(SS_N), .q_o(ssLevel), .rise_o(ssRise), .fall_o(ssFall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) uMosiSync (
    .clk(clk), .rst(rst), .d_i(MOSI), .q_o(mosiSync), .rise_o(mosiRise), .fall_o(mosiFall)
  );

  assign unusedSync = ^{sckLevel, mosiRise, mosiFall};

  spiState_e   state_q, state_d;
  wordSize_e   wordSize_q, wordSize_d;
  logic [3:0]  bitCnt_q, bitCnt_d;
  logic [15:0] rxShift_q, rxShift_d;
  logic [15:0] txShift_q, txShift_d;
  logic        miso_q, miso_d;
  logic [15:0] rx_q, rx_d;
  logic        rxReady_q, rxReady_d;
  logic [15:0] holdData_q, holdData_d;
  logic        holdBoth_q, holdBoth_d;
  logic        txEmpty_q, txEmpty_d;

  logic        txLoad, wordDone;
  logic [15:0] loadWord, rxWord;
  wordSize_e   loadSize;
  logic [3:0]  lastBit;

`ifdef SPISLAVE_STATUS_EN
  logic [1:0]  status_q, status_d;
`endif

  // The TX shifter always holds the next bit for the coming SCK fall in its MSB;
  // the SS_N fall additionally pre-drives that bit so it is valid before the first fall.
  always_comb begin
    state_d    = state_q;
    wordSize_d = wordSize_q;
    bitCnt_d   = bitCnt_q;
    rxShift_d  = rxShift_q;
    txShift_d  = txShift_q;
    miso_d     = miso_q;
    rx_d       = rx_q;
    rxReady_d  = rxReady_q & ~rd;
    holdData_d = holdData_q;
    holdBoth_d = holdBoth_q;
    txEmpty_d  = txEmpty_q;
    txLoad     = 1'b0;
    wordDone   = 1'b0;
    loadWord   = txEmpty_q ? {IDLE_TX, IDLE_TX} : byteSwap(holdData_q);
    loadSize   = (!txEmpty_q && holdBoth_q) ? WS16 : WS8;
    rxWord     = {rxShift_q[14:0], mosiSync};
    lastBit    = (wordSize_q == WS16) ? 4'd15 : 4'd7;

    case (state_q)
      IDLE: begin
        if (ssFall) begin
          state_d  = ACTIVE;
          bitCnt_d = 4'd0;
          txLoad   = 1'b1;
          miso_d   = loadWord[15];
        end
      end
      ACTIVE: begin
        if (ssRise) begin
          state_d  = IDLE;
          bitCnt_d = 4'd0;
          miso_d   = 1'b1;
        end else begin
          if (sckFall) begin
            miso_d    = txShift_q[15];
            txShift_d = {txShift_q[14:0], 1'b0};
          end
          if (sckRise) begin
            rxShift_d = rxWord;
            bitCnt_d  = bitCnt_q + 4'd1;
            if (bitCnt_q == lastBit) begin
              wordDone = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (wordDone) begin
      rx_d      = (wordSize_q == WS16) ? byteSwap(rxWord) : {8'h00, rxWord[7:0]};
      rxReady_d = 1'b1;
      bitCnt_d  = 4'd0;
      txLoad    = 1'b1;
    end

    if (txLoad) begin
      txShift_d  = loadWord;
      wordSize_d = loadSize;
      txEmpty_d  = 1'b1;
    end

    // A write in the same cycle as a load lands after the load has taken the old value.
    if (we) begin
      holdData_d = tx;
      holdBoth_d = both;
      txEmpty_d  = 1'b0;
    end

`ifdef SPISLAVE_STATUS_EN
    status_d = rd ? 2'b00 : status_q;
    if (wordDone && rxReady_q) status_d[0] = 1'b1;
    if (txLoad && txEmpty_q)   status_d[1] = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wordSize_q <= WS8;
      bitCnt_q   <= 4'd0;
      rxShift_q  <= 16'h0000;
      txShift_q  <= 16'h0000;
      miso_q     <= 1'b1;
      rx_q       <= 16'h0000;
      rxReady_q  <= 1'b0;
      holdData_q <= 16'h0000;
      holdBoth_q <= 1'b0;
      txEmpty_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      wordSize_q <= wordSize_d;
      bitCnt_q   <= bitCnt_d;
      rxShift_q  <= rxShift_d;
      txShift_q  <= txShift_d;
      miso_q     <= miso_d;
      rx_q       <= rx_d;
      rxReady_q  <= rxReady_d;
      holdData_q <= holdData_d;
      holdBoth_q <= holdBoth_d;
      txEmpty_q  <= txEmpty_d;
    end
  end

`ifdef SPISLAVE_STATUS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= 2'b00;
    end else begin
      status_q <= status_d;
    end
  end

  assign status = status_q;
`endif

  assign rx       = rx_q;
  assign rx_ready = rxReady_q;
  assign tx_empty = txEmpty_q;
  assign selected = ~ssLevel;
  assign MISO     = miso_q;
  assign MISO_OE  = ~ssLevel;

endmodule

// File: tb/tb_spislave_le.sv
// Randomised bench for spislave_le: an SPI mode-3 master plus a byte-level reference
// model; a monitor scores every received word against a queue of expected words.
module tb_spislave_le;

  localparam logic [7:0] IDLE_BYTE = 8'h00;

  logic        clk, rst, we, both, rd;
  logic [15:0] tx, rx;
  logic        rx_ready, tx_empty, selected;
  logic        SCK, SS_N, MOSI, MISO, MISO_OE;
`ifdef SPISLAVE_STATUS_EN
  logic [1:0]  status;
`endif

  spislave_le #(.SYNC_STAGES(2), .IDLE_TX(IDLE_BYTE)) dut (
    .clk(clk), .rst(rst), .we(we), .both(both), .tx(tx), .rd(rd),
    .rx(rx), .rx_ready(rx_ready), .tx_empty(tx_empty), .selected(selected),
`ifdef SPISLAVE_STATUS_EN
    .status(status),
`endif
    .SCK(SCK), .SS_N(SS_N), .MOSI(MOSI), .MISO(MISO), .MISO_OE(MISO_OE)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks = 0;
  int          errors = 0;
  logic [15:0] expQ[$];
  logic [15:0] mosiPlan[$];

  // Reference model state: holding word, expected rx/rx_ready and sticky flags.
  bit          mPending;
  logic [15:0] mData;
  bit          mBoth;
  logic [15:0] mRx;
  bit          mReady;
  logic [1:0]  mStatus;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic modelReset();
    mPending = 0; mData = 16'h0; mBoth = 0;
    mRx = 16'h0; mReady = 0; mStatus = 2'b00;
  endtask

  task automatic modelLoad(output int size, output logic [15:0] txw);
    if (mPending) begin
      size = mBoth ? 16 : 8;
      txw  = mData;
      mPending = 0;
    end else begin
      size = 8;
      txw  = {IDLE_BYTE, IDLE_BYTE};
      mStatus[1] = 1'b1;
    end
  endtask

  task automatic modelComplete(input logic [15:0] rxv);
    if (mReady) mStatus[0] = 1'b1;
    mReady = 1;
    mRx    = rxv;
  endtask

  task automatic cpuWrite(input logic [15:0] d, input bit b);
    we = 1'b1; tx = d; both = b;
    mData = d; mBoth = b; mPending = 1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic doRd();
    rd = 1'b1; mReady = 0; mStatus = 2'b00;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic checkIdleState(input string tag);
    checkOutput({tag, "_tx_empty"}, 16'(tx_empty), 16'(!mPending));
    checkOutput({tag, "_rx_ready"}, 16'(rx_ready), 16'(mReady));
    checkOutput({tag, "_rx"}, rx, mRx);
    checkOutput({tag, "_miso_idle"}, {14'h0, MISO_OE, MISO}, 16'h0001);
`ifdef SPISLAVE_STATUS_EN
    checkOutput({tag, "_status"}, 16'(status), 16'(mStatus));
`endif
  endtask

  // One SS_N frame of nWords words at SCK = clk/8. abortAfter > 0 cuts the first word
  // short; doReset then pulses rst instead of a clean deselect.
  task automatic applyStimulus(input int nWords, input bit autoRd, input int abortAfter,
                               input bit doReset, input bit midWrite,
                               input logic [15:0] midData, input bit midBoth);
    int          size, nb;
    logic [15:0] txw, mosiW, expMiso, gotMiso, expRx;
    bit          rdReq;
    rdReq = 0;
    SS_N  = 1'b0;
    modelLoad(size, txw);
    repeat (6) @(negedge clk);
    checkOutput("selected_active", {14'h0, selected, MISO_OE}, 16'h0003);
    for (int w = 0; w < nWords; w++) begin
      mosiW   = (mosiPlan.size() > 0) ? mosiPlan.pop_front() : 16'($urandom);
      nb      = (abortAfter > 0) ? abortAfter : size;
      expMiso = (size == 16) ? {txw[7:0], txw[15:8]} : {txw[7:0], 8'h00};
      expRx   = (size == 16) ? {mosiW[7:0], mosiW[15:8]} : {8'h00, mosiW[15:8]};
      gotMiso = 16'h0;
      if (abortAfter == 0) expQ.push_back(expRx);
      for (int i = 0; i < nb; i++) begin
        SCK  = 1'b0;
        MOSI = mosiW[15-i];
        if (rdReq) begin
          rd = 1'b1; mReady = 0; mStatus = 2'b00;
        end
        rdReq = 0;
        @(negedge clk);
        rd = 1'b0;
        if (midWrite && w == 0 && i == 4) begin
          cpuWrite(midData, midBoth);
          repeat (2) @(negedge clk);
        end else begin
          repeat (3) @(negedge clk);
        end
        gotMiso = {gotMiso[14:0], MISO};
        SCK = 1'b1;
        repeat (4) @(negedge clk);
      end
      checkOutput("miso_word", gotMiso, expMiso >> (16 - nb));
      if (abortAfter > 0) break;
      modelComplete(expRx);
      modelLoad(size, txw);
      if (autoRd) rdReq = 1;
    end
    if (doReset) begin
      rst = 1'b1;
      #1;
      checkOutput("rst_rx", rx, 16'h0000);
      checkOutput("rst_flags", {13'h0, rx_ready, tx_empty, selected}, 16'h0002);
      checkOutput("rst_miso", {14'h0, MISO_OE, MISO}, 16'h0001);
      modelReset();
      SS_N = 1'b1; SCK = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
    end else begin
      SS_N = 1'b1;
      @(negedge clk);
      if (rdReq) doRd();
    end
    repeat (8) @(negedge clk);
  endtask

  // Monitor: a new word is presented when rx_ready rises or rx changes while it is set.
  initial begin
    logic        prevReady;
    logic [15:0] prevRx, expv;
    prevReady = 1'b0;
    prevRx    = 16'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prevReady = 1'b0;
        prevRx    = 16'h0;
      end else begin
        if (rx_ready && (!prevReady || rx !== prevRx)) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL rx_unexpected: got %h expected no word", rx);
          end else begin
            expv = expQ.pop_front();
            checkOutput("rx_word", rx, expv);
          end
        end
        prevReady = rx_ready;
        prevRx    = rx;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; we = 1'b0; both = 1'b0; tx = 16'h0; rd = 1'b0;
    SCK = 1'b1; SS_N = 1'b1; MOSI = 1'b1;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_rx", rx, 16'h0000);
    checkOutput("reset_flags", {13'h0, rx_ready, tx_empty, selected}, 16'h0002);
    checkOutput("reset_miso", {14'h0, MISO_OE, MISO}, 16'h0001);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] 8-bit word");
    cpuWrite(16'h00A5, 1'b0);
    checkOutput("tx_empty_after_write", 16'(tx_empty), 16'h0000);
    mosiPlan.push_back(16'h3C00);
    applyStimulus(1, 1'b0, 0, 1'b0, 1'b0, 16'h0, 1'b0);
    checkIdleState("w8");
    doRd();

    $display("[TB] 16-bit word");
    cpuWrite(16'h1234, 1'b1);
    mosiPlan.push_back(16'hABCD);
    applyStimulus(1, 1'b1, 0, 1'b0, 1'b0, 16'h0, 1'b0);
    checkIdleState("w16");

    $display("[TB] back-to-back 16-bit words");
    cpuWrite(16'($urandom), 1'b1);
    applyStimulus(2, 1'b1, 0, 1'b0, 1'b1, 16'hBEEF, 1'b1);
    checkIdleState("b2b");

    $display("[TB] deselect mid-word");
    cpuWrite(16'($urandom), 1'b0);
    applyStimulus(1, 1'b1, 5, 1'b0, 1'b0, 16'h0, 1'b0);
    checkIdleState("abort");
    applyStimulus(1, 1'b1, 0, 1'b0, 1'b0, 16'h0, 1'b0);
    checkIdleState("after_abort");

    $display("[TB] idle transmit and sticky flags");
    doRd();
    mosiPlan.push_back(16'h5A00);
    applyStimulus(1, 1'b0, 0, 1'b0, 1'b0, 16'h0, 1'b0);
    checkIdleState("underrun");
    mosiPlan.push_back(16'hC300);
    applyStimulus(1, 1'b0, 0, 1'b0, 1'b0, 16'h0, 1'b0);
    checkIdleState("overrun");
    doRd();
    repeat (2) @(negedge clk);
    checkIdleState("flags_cleared");

    $display("[TB] random frames");
    for (int f = 0; f < 12; f++) begin
      if ($urandom_range(0, 3) != 0) cpuWrite(16'($urandom), 1'($urandom_range(0, 1)));
      applyStimulus($urandom_range(1, 3), 1'b1, 0, 1'b0, 1'($urandom_range(0, 1)),
                    16'($urandom), 1'($urandom_range(0, 1)));
      checkIdleState("random");
    end

    $display("[TB] reset mid-word");
    cpuWrite(16'($urandom), 1'b1);
    applyStimulus(1, 1'b1, 7, 1'b1, 1'b0, 16'h0, 1'b0);
    checkIdleState("post_reset");
    cpuWrite(16'($urandom), 1'b1);
    applyStimulus(1, 1'b1, 0, 1'b0, 1'b0, 16'h0, 1'b0);
    checkIdleState("post_reset_frame");

    repeat (4) @(negedge clk);
    checkOutput("rx_queue_left", 16'(expQ.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
